// File: rtl/cla_sub_if.sv
// Operand/result handshake bundle for the pipelined CLA subtractor.
// master = producer/consumer environment, slave = the subtractor.
interface cla_sub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/cla_sub_pipe.sv
// Pipelined two's-complement subtractor: diff = a - b - bin, computed as
// a + ~b + ~bin with one 8-bit carry-lookahead slice resolved per stage.
// Unresolved operand slices and already-resolved result slices travel down
// the pipe together; the whole pipe stalls as one unit on backpressure.
module cla_sub_pipe #(
    parameter  int WIDTH  = 32,
    parameter  int SLICE  = 8,
    localparam int STAGES = WIDTH / SLICE
) (
    input logic      clk,
    input logic      rst,
    cla_sub_if.slave bus
);

    // One slice of lookahead: every carry is formed from the running group
    // generate/propagate prefix and the slice carry-in, never rippled.
    // Returns {carry_out, sum}.
    function automatic logic [SLICE:0] cla_slice(
        input logic [SLICE-1:0] x,
        input logic [SLICE-1:0] y,
        input logic             cin
    );
        logic [SLICE-1:0] p;
        logic [SLICE-1:0] g;
        logic [SLICE:0]   c;
        logic             grp_g;
        logic             grp_p;
        // NOTE: blocking assignments here are deliberate -- this is pure
        // combinational evaluation where each line uses the previous result.
        p     = x ^ y;
        g     = x & y;
        c[0]  = cin;
        grp_g = 1'b0;
        grp_p = 1'b1;
        for (int i = 0; i < SLICE; i++) begin
            grp_g  = g[i] | (p[i] & grp_g);
            grp_p  = grp_p & p[i];
            c[i+1] = grp_g | (grp_p & cin);
        end
        return {c[SLICE], p ^ c[SLICE-1:0]};
    endfunction

    // Whole-pipe advance: the output stage is empty or being drained.
    logic advance;

    for (genvar s = 0; s < STAGES; s++) begin : stg
        // Operand bits still unresolved when entering this stage.
        localparam int RW = WIDTH - s * SLICE;

        logic [RW-1:0]          a_in;
        logic [RW-1:0]          nb_in;
        logic                   c_in;
        logic                   z_in;
        logic                   v_in;
        logic [SLICE:0]         res;
        logic [(s+1)*SLICE-1:0] d_nxt;
        logic [(s+1)*SLICE-1:0] d_q;
        logic                   z_q;
        logic                   v_q;

        if (s == 0) begin : g_first
            assign a_in  = bus.a;
            assign nb_in = ~bus.b;
            assign c_in  = ~bus.bin;
            assign z_in  = 1'b1;
            assign v_in  = bus.in_valid;
            assign d_nxt = res[SLICE-1:0];
        end else begin : g_next
            assign a_in  = stg[s-1].g_fwd.a_q;
            assign nb_in = stg[s-1].g_fwd.nb_q;
            assign c_in  = stg[s-1].g_fwd.c_q;
            assign z_in  = stg[s-1].z_q;
            assign v_in  = stg[s-1].v_q;
            assign d_nxt = {res[SLICE-1:0], stg[s-1].d_q};
        end

        assign res = cla_slice(a_in[SLICE-1:0], nb_in[SLICE-1:0], c_in);

        // Resolved result bits, running zero flag and valid bit for this stage.
        // NOTE: datapath registers are reset too, because the result outputs
        // are taken straight from the last stage and must read 0 in reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                d_q <= '0;
                z_q <= 1'b0;
                v_q <= 1'b0;
            end else if (advance) begin
                d_q <= d_nxt;
                z_q <= z_in & (res[SLICE-1:0] == '0);
                v_q <= v_in;
            end
        end

        if (s < STAGES - 1) begin : g_fwd
            logic [RW-SLICE-1:0] a_q;
            logic [RW-SLICE-1:0] nb_q;
            logic                c_q;

            // Forward unused operand slices and the slice carry to the next stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q  <= '0;
                    nb_q <= '0;
                    c_q  <= 1'b0;
                end else if (advance) begin
                    a_q  <= a_in[RW-1:SLICE];
                    nb_q <= nb_in[RW-1:SLICE];
                    c_q  <= res[SLICE];
                end
            end
        end else begin : g_last
            logic bout_q;
            logic ovf_q;
            logic ovf_nxt;

            // Signed overflow: operand signs differ (a sign equals ~b sign)
            // and the result sign departs from the minuend sign.
            assign ovf_nxt = (a_in[RW-1] == nb_in[RW-1]) &
                             (d_nxt[WIDTH-1] != a_in[RW-1]);

            // Borrow-out and overflow flags, registered with the top slice.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end else if (advance) begin
                    bout_q <= ~res[SLICE];
                    ovf_q  <= ovf_nxt;
                end
            end
        end
    end

    assign advance       = ~stg[STAGES-1].v_q | bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = stg[STAGES-1].v_q;
    assign bus.diff      = stg[STAGES-1].d_q;
    assign bus.zero      = stg[STAGES-1].z_q;
    assign bus.bout      = stg[STAGES-1].g_last.bout_q;
    assign bus.ovf       = stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Self-checking bench for cla_sub_pipe: directed vectors, randomized
// backpressure, bubble spacing/latency and mid-stream reset, against an
// arithmetic reference model and an in-order expectation queue.
module tb_cla_sub_pipe;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    cla_sub_if #(.WIDTH(W)) bus ();

    cla_sub_pipe #(.WIDTH(W), .SLICE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
        int           acc;
    } exp_t;

    exp_t q[$];
    exp_t nxt;
    int   cyc;
    int   n_checks;
    int   n_pass;
    bit   chk_lat;
    bit   in_fired;
    int   sent;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic [W-1:0] d, input logic bo, input logic ov, input logic z);
        exp_t e;
        e.diff = d;
        e.bout = bo;
        e.ovf  = ov;
        e.zero = z;
        e.acc  = 0;
        return e;
    endfunction

    // Reference: plain wide arithmetic plus the sign rule for overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t        e;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] full;
        ua     = {32'd0, a};
        ub     = {32'd0, b} + {63'd0, bin};
        full   = ua - ub;
        e.diff = full[W-1:0];
        e.bout = (ua < ub);
        e.ovf  = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
        e.zero = (e.diff == '0);
        e.acc  = 0;
        return e;
    endfunction

    task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input exp_t e);
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        bus.in_valid = 1'b1;
        nxt          = e;
    endtask

    task automatic offer_rand();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        a   = $urandom;
        b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
        bin = 1'($urandom_range(0, 1));
        offer(a, b, bin, model(a, b, bin));
    endtask

    // One clock: check handshake, score transfers, advance, check stall hold.
    task automatic cycle();
        logic        out_fire;
        logic        stalled;
        logic [35:0] snap;
        exp_t        e;
        #1;
        check("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
        if (q.size() == 0) check("no_stale_valid", bus.out_valid, 0);
        in_fired = bus.in_valid && bus.in_ready;
        out_fire = bus.out_valid && bus.out_ready;
        if (out_fire && q.size() != 0) begin
            e = q.pop_front();
            check("diff", bus.diff, e.diff);
            check("bout", bus.bout, e.bout);
            check("ovf", bus.ovf, e.ovf);
            check("zero", bus.zero, e.zero);
            if (chk_lat) check("latency", cyc - e.acc - 1, 3);
        end
        if (in_fired) begin
            e     = nxt;
            e.acc = cyc;
            q.push_back(e);
        end
        stalled = bus.out_valid && !bus.out_ready;
        snap    = {bus.out_valid, bus.diff, bus.bout, bus.ovf, bus.zero};
        @(posedge clk);
        cyc++;
        #1;
        if (stalled) check("stall_hold", {bus.out_valid, bus.diff, bus.bout, bus.ovf, bus.zero}, snap);
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
        check("drain_empty", q.size(), 0);
        repeat (3) cycle();
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        cyc           = 0;
        chk_lat       = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state.
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_diff", bus.diff, 0);
        check("rst_bout", bus.bout, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_zero", bus.zero, 0);
        check("rst_in_ready", bus.in_ready, 1);
        #11;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors, back to back, with latency checks.
        bus.out_ready = 1'b1;
        chk_lat       = 1'b1;
        offer(32'h0000_0005, 32'h0000_0003, 1'b0, mk(32'h0000_0002, 1'b0, 1'b0, 1'b0));
        cycle();
        offer(32'h0000_0100, 32'h0000_0001, 1'b0, mk(32'h0000_00FF, 1'b0, 1'b0, 1'b0));
        cycle();
        offer(32'h0000_0000, 32'h0000_0001, 1'b0, mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0));
        cycle();
        offer(32'h8000_0000, 32'h0000_0001, 1'b0, mk(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0));
        cycle();
        offer(32'h1234_5678, 32'h1234_5677, 1'b1, mk(32'h0000_0000, 1'b0, 1'b0, 1'b1));
        cycle();
        drain();

        // Backpressure: 8 back-to-back random ops, out_ready toggling.
        chk_lat      = 1'b0;
        sent         = 0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 300 && sent < 8; i++) begin
            if (!bus.in_valid) offer_rand();
            bus.out_ready = 1'($urandom_range(0, 1));
            cycle();
            if (in_fired) begin
                sent++;
                bus.in_valid = 1'b0;
            end
        end
        check("bp_sent", sent, 8);
        drain();

        // Bubbles: gaps of 1-2 idle cycles, result must land 3 edges after accept.
        chk_lat       = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            offer_rand();
            cycle();
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) cycle();
        end
        drain();

        // Reset mid-stream: fill the pipe under stall, then reset between edges.
        chk_lat       = 1'b0;
        bus.out_ready = 1'b0;
        offer(32'h0000_0000, 32'h0000_0001, 1'b0, mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0));
        cycle();
        check("rst_fill_accept", in_fired, 1);
        for (int i = 0; i < 3; i++) begin
            offer_rand();
            cycle();
            check("rst_fill_accept", in_fired, 1);
        end
        bus.in_valid = 1'b0;
        check("rst_pre_valid", bus.out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_diff", bus.diff, 0);
        check("midrst_bout", bus.bout, 0);
        check("midrst_ovf", bus.ovf, 0);
        check("midrst_zero", bus.zero, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        q.delete();
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (5) cycle();
        chk_lat = 1'b1;
        offer(32'h0000_0005, 32'h0000_0003, 1'b0, mk(32'h0000_0002, 1'b0, 1'b0, 1'b0));
        cycle();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
